// File: rtl/peripheral_ahb3_pkg.sv
// peripheral_ahb3_pkg: AHB3-Lite encoding constants shared by the APB4-to-AHB3 bridge
// No ports; exports HTRANS/HSIZE/HBURST/HRESP/HPROT encodings.
package peripheral_ahb3_pkg;
    localparam logic [1:0] HTRANS_IDLE      = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ    = 2'b10;
    localparam logic [2:0] HSIZE_BYTE       = 3'b000;
    localparam logic [2:0] HSIZE_HWORD      = 3'b001;
    localparam logic [2:0] HSIZE_WORD       = 3'b010;
    localparam logic [2:0] HBURST_SINGLE    = 3'b000;
    localparam logic       HRESP_ERROR      = 1'b1;
    localparam logic [3:0] HPROT_OPCODE     = 4'b0000;
    localparam logic [3:0] HPROT_DATA       = 4'b0001;
    localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
endpackage

// File: rtl/peripheral_apb42ahb3_master_if.sv
// peripheral_apb42ahb3_master_if: APB4 completer side and AHB3-Lite manager side of the bridge
// Modports: slave = the bridge (APB in, AHB address/data out); master = APB requester plus AHB responder.
interface peripheral_apb42ahb3_master_if #(
    parameter int HADDR_SIZE = 32,
    parameter int PADDR_SIZE = 16
);
    logic                  PSEL;
    logic                  PENABLE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HRESP;
    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, HRDATA, HREADY, HRESP,
        output PRDATA, PREADY, PSLVERR, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, HRDATA, HREADY, HRESP,
        input  PRDATA, PREADY, PSLVERR, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
endinterface

// File: rtl/peripheral_apb42ahb3_master_strb_decode.sv
// peripheral_apb4_strb_decode: maps an APB write strobe to AHB transfer size and byte lane
// Ports: i_write, i_strb in; o_hsize, o_offset (byte offset in word), o_illegal out.
module peripheral_apb4_strb_decode
    import peripheral_ahb3_pkg::*;
(
    input  logic       i_write,
    input  logic [3:0] i_strb,
    output logic [2:0] o_hsize,
    output logic [1:0] o_offset,
    output logic       o_illegal
);
    // Reads and empty-strobe writes decode as an aligned word; the top skips the bus for the latter.
    always_comb begin
        o_hsize   = HSIZE_WORD;
        o_offset  = 2'd0;
        o_illegal = 1'b0;
        if (i_write) begin
            case (i_strb)
                4'b0000, 4'b1111: o_hsize = HSIZE_WORD;
                4'b0011: o_hsize = HSIZE_HWORD;
                4'b1100: begin o_hsize = HSIZE_HWORD; o_offset = 2'd2; end
                4'b0001: o_hsize = HSIZE_BYTE;
                4'b0010: begin o_hsize = HSIZE_BYTE; o_offset = 2'd1; end
                4'b0100: begin o_hsize = HSIZE_BYTE; o_offset = 2'd2; end
                4'b1000: begin o_hsize = HSIZE_BYTE; o_offset = 2'd3; end
                default: o_illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/peripheral_apb42ahb3_master.sv
// peripheral_apb42ahb3_master: APB4 completer bridging each APB transfer to one AHB3-Lite single transfer
// Ports: HCLK clock, HRESET sync active-high reset, bus (slave modport: APB in/out, AHB out/in).
module peripheral_apb42ahb3_master
    import peripheral_ahb3_pkg::*;
#(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    PADDR_SIZE = 16,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
    input logic                          HCLK,
    input logic                          HRESET,
    peripheral_apb42ahb3_master_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t                r_state;
    logic [1:0]            r_htrans;
    logic [HADDR_SIZE-1:0] r_haddr;
    logic [31:0]           r_hwdata;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [3:0]            r_hprot;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [31:0]           r_prdata;
    logic [2:0]            w_hsize;
    logic [1:0]            w_offset;
    logic                  w_illegal;
    logic                  w_start;
    logic                  w_skip;
    logic                  w_herr;
    logic [HADDR_SIZE-1:0] w_haddr;
    logic [3:0]            w_hprot;
    peripheral_apb4_strb_decode u_decode (
        .i_write   (bus.PWRITE),
        .i_strb    (bus.PSTRB),
        .o_hsize   (w_hsize),
        .o_offset  (w_offset),
        .o_illegal (w_illegal)
    );
    assign w_start = bus.PSEL & ~bus.PENABLE;
    assign w_skip  = bus.PWRITE & (bus.PSTRB == 4'b0000);
    assign w_herr  = bus.HRESP == HRESP_ERROR;
    // Lane offset replaces the two low PADDR bits; the sum wraps at the AHB address width.
    assign w_haddr = HADDR_BASE + HADDR_SIZE'({bus.PADDR[PADDR_SIZE-1:2], w_offset});
    assign w_hprot = (bus.PPROT[0] ? HPROT_PRIVILEGED : HPROT_OPCODE) | (bus.PPROT[2] ? HPROT_OPCODE : HPROT_DATA);
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= IDLE;
            r_htrans  <= HTRANS_IDLE;
            r_haddr   <= '0;
            r_hwdata  <= '0;
            r_hwrite  <= 1'b0;
            r_hsize   <= HSIZE_BYTE;
            r_hprot   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    if (w_illegal || w_skip) begin
                        r_state   <= RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_illegal;
                        r_prdata  <= '0;
                    end else begin
                        r_state  <= ADDR;
                        r_htrans <= HTRANS_NONSEQ;
                        r_haddr  <= w_haddr;
                        r_hwrite <= bus.PWRITE;
                        r_hsize  <= w_hsize;
                        r_hprot  <= w_hprot;
                        // Loaded early; HWDATA only matters in the data phase that follows.
                        r_hwdata <= bus.PWDATA;
                    end
                end
                ADDR: if (bus.HREADY) begin
                    r_state  <= DATA;
                    r_htrans <= HTRANS_IDLE;
                end
                DATA: if (bus.HREADY) begin
                    r_state   <= RESP;
                    r_pready  <= 1'b1;
                    r_pslverr <= w_herr;
                    r_prdata  <= (r_hwrite || w_herr) ? 32'd0 : bus.HRDATA;
                end
                default: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
            endcase
        end
    end
    assign bus.HTRANS    = r_htrans;
    assign bus.HADDR     = r_haddr;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HPROT     = r_hprot;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.PREADY    = r_pready;
    assign bus.PSLVERR   = r_pslverr;
    assign bus.PRDATA    = r_prdata;
endmodule

// File: tb/tb_peripheral_apb42ahb3_master.sv
// tb_peripheral_apb42ahb3_master: directed bench with a transaction-level model and per-cycle compare
module tb_peripheral_apb42ahb3_master;
    import peripheral_ahb3_pkg::*;
    localparam logic [31:0] BASE = 32'hFFFF_1000;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    peripheral_apb42ahb3_master_if #(.HADDR_SIZE(32), .PADDR_SIZE(16)) bus ();
    peripheral_apb42ahb3_master #(.HADDR_SIZE(32), .PADDR_SIZE(16), .HADDR_BASE(BASE)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );
    int tests = 0, fails = 0, cyc = 0;
    int exp_resp = -1, a_lo = 1, a_hi = 0, d_lo = 1, d_hi = 0;
    logic        exp_err, exp_hwrite;
    logic [31:0] exp_rdata, exp_haddr, exp_hwdata;
    logic [2:0]  exp_hsize;
    logic [3:0]  exp_hprot;
    bit chk_on = 0, rsp, ns;
    int last_s, last_resp, n_resp = 0, n_ahb = 0, k0, k1;
    logic [31:0] last_haddr, last_prdata;
    logic [2:0]  last_hsize;
    logic [3:0]  last_hprot;
    logic        last_err;
    logic [1:0]  prev_ht = 2'b00;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Strobe legality from first principles: contiguous run of 1/2/4 lanes, naturally aligned.
    task automatic model(input logic w, input logic [3:0] st, output bit legal, output int off, output logic [2:0] sz);
        int n = 0, lo = 0;
        for (int i = 3; i >= 0; i--) if (st[i]) begin n++; lo = i; end
        if (!w || n == 0) begin
            legal = 1; off = 0; sz = 3'd2;
        end else begin
            legal = (n == 1 || n == 2 || n == 4) && (lo % n == 0) && (int'(st >> lo) == (1 << n) - 1);
            off = lo;
            sz = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
        end
    endtask
    always @(negedge clk) if (chk_on) begin
        rsp = (cyc == exp_resp);
        ns = (cyc >= a_lo && cyc <= a_hi);
        chk("pready", 32'(bus.PREADY), 32'(rsp));
        chk("pslverr", 32'(bus.PSLVERR), 32'(rsp && exp_err));
        if (rsp) begin
            chk("prdata", bus.PRDATA, exp_rdata);
            n_resp++;
            last_resp = cyc;
            last_prdata = bus.PRDATA;
            last_err = bus.PSLVERR;
        end
        chk("htrans", 32'(bus.HTRANS), 32'(ns ? HTRANS_NONSEQ : HTRANS_IDLE));
        if (ns) begin
            chk("haddr", bus.HADDR, exp_haddr);
            chk("hsize", 32'(bus.HSIZE), 32'(exp_hsize));
            chk("hwrite", 32'(bus.HWRITE), 32'(exp_hwrite));
            chk("hprot", 32'(bus.HPROT), 32'(exp_hprot));
        end
        if (bus.HTRANS == HTRANS_NONSEQ) begin
            if (prev_ht != HTRANS_NONSEQ) n_ahb++;
            last_haddr = bus.HADDR;
            last_hsize = bus.HSIZE;
            last_hprot = bus.HPROT;
        end
        prev_ht = bus.HTRANS;
        if (exp_hwrite && cyc >= d_lo && cyc <= d_hi) chk("hwdata", bus.HWDATA, exp_hwdata);
        chk("hburst", 32'(bus.HBURST), 32'(HBURST_SINGLE));
        chk("hmastlock", 32'(bus.HMASTLOCK), 32'd0);
    end
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.PSEL = 0; bus.PENABLE = 0; bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = JUNK;
        end
    endtask
    // One APB transfer: aw/dw = AHB address/data wait states, er = two-cycle ERROR,
    // rst_at = transfer cycle in which HRESET pulses (0 = never), drop = release PSEL after setup.
    task automatic apb(input logic [15:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] pr, input int aw, input int dw, input bit er, input logic [31:0] rd,
                       input int rst_at, input bit drop);
        bit legal, xfer;
        int off, lat, s, j;
        logic [2:0] sz;
        @(posedge clk); #1;
        model(w, st, legal, off, sz);
        xfer = legal && !(w && st == 4'b0000);
        lat = xfer ? 3 + aw + dw + int'(er) : 1;
        s = cyc;
        last_s = s;
        exp_resp = s + lat;
        exp_err = !legal || (xfer && er);
        exp_rdata = (xfer && !w && !er) ? rd : 32'd0;
        a_lo = xfer ? s + 1 : 1;
        a_hi = xfer ? s + 1 + aw : 0;
        d_lo = s + 2 + aw;
        d_hi = xfer ? s + lat - 1 : 0;
        exp_haddr = 32'((64'(BASE) + 64'((a / 4) * 4) + 64'(off)) % 64'h1_0000_0000);
        exp_hsize = sz;
        exp_hwrite = w;
        exp_hprot = {2'b00, pr[0], ~pr[2]};
        exp_hwdata = wd;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = wd; bus.PSTRB = st; bus.PPROT = pr;
        bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = JUNK;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (rst_at == k) begin
                rst = 1;
                exp_resp = -1; a_lo = 1; a_hi = 0; d_lo = 1; d_hi = 0;
                @(posedge clk); #1;
                rst = 0;
                bus.PSEL = 0; bus.PENABLE = 0; bus.HREADY = 1; bus.HRESP = 0;
                return;
            end
            bus.PSEL = !drop; bus.PENABLE = !drop;
            bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = JUNK;
            if (xfer && k < lat) begin
                if (k <= 1 + aw) bus.HREADY = (k == 1 + aw);
                else begin
                    j = k - (2 + aw);
                    if (j < dw) bus.HREADY = 0;
                    else if (er && j == dw) begin bus.HREADY = 0; bus.HRESP = 1; end
                    else begin bus.HREADY = 1; bus.HRESP = er; bus.HRDATA = rd; end
                end
            end
        end
    endtask
    initial begin
        bus.PSEL = 0; bus.PENABLE = 0; bus.PADDR = 0; bus.PWRITE = 0; bus.PWDATA = 0; bus.PSTRB = 0; bus.PPROT = 0;
        bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = JUNK;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
        chk("rst_hprot", 32'(bus.HPROT), 32'd0);
        chk("rst_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        rst = 0;
        chk_on = 1;
        apb(16'h0010, 1, 32'hDEAD_BEEF, 4'b1111, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("word_haddr", last_haddr, 32'hFFFF_1010);
        chk("word_hsize", 32'(last_hsize), 32'd2);
        chk("word_lat", last_resp - last_s, 32'd3);
        chk("word_err", 32'(last_err), 32'd0);
        apb(16'h0020, 1, 32'h00AB_0000, 4'b0100, 3'b001, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("byte_haddr", last_haddr, 32'hFFFF_1022);
        chk("byte_hsize", 32'(last_hsize), 32'd0);
        chk("byte_hprot", 32'(last_hprot), 32'b0011);
        k0 = n_ahb;
        apb(16'h0020, 1, 32'h1111_1111, 4'b0110, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("s0110_err", 32'(last_err), 32'd1);
        chk("s0110_noahb", n_ahb - k0, 32'd0);
        chk("s0110_lat", last_resp - last_s, 32'd1);
        apb(16'h0004, 0, 32'h0, 4'b0000, 3'b100, 0, 2, 0, 32'h1234_5678, 0, 0); idle(1);
        chk("rd_prdata", last_prdata, 32'h1234_5678);
        chk("rd_lat", last_resp - last_s, 32'd5);
        chk("rd_hprot", 32'(last_hprot), 32'b0000);
        k0 = n_resp;
        apb(16'h0008, 0, 32'h0, 4'b0000, 3'b000, 0, 0, 1, 32'h55AA_55AA, 0, 0); idle(1);
        chk("err_pslverr", 32'(last_err), 32'd1);
        chk("err_prdata", last_prdata, 32'd0);
        chk("err_one_pready", n_resp - k0, 32'd1);
        apb(16'h0040, 1, 32'h1234_5678, 4'b1100, 3'b101, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("hw_hi_haddr", last_haddr, 32'hFFFF_1042);
        chk("hw_hi_hsize", 32'(last_hsize), 32'd1);
        chk("hw_hi_hprot", 32'(last_hprot), 32'b0010);
        apb(16'h0052, 1, 32'h0000_9ABC, 4'b0011, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("hw_lo_haddr", last_haddr, 32'hFFFF_1050);
        apb(16'h0061, 1, 32'h7700_0000, 4'b1000, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("b3_haddr", last_haddr, 32'hFFFF_1063);
        k0 = n_ahb;
        apb(16'h0070, 1, 32'hFFFF_FFFF, 4'b0000, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("s0000_err", 32'(last_err), 32'd0);
        chk("s0000_noahb", n_ahb - k0, 32'd0);
        apb(16'h0070, 1, 32'h0, 4'b0101, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("s0101_err", 32'(last_err), 32'd1);
        apb(16'h0070, 1, 32'h0, 4'b0111, 3'b000, 0, 0, 0, JUNK, 0, 0); idle(1);
        chk("s0111_err", 32'(last_err), 32'd1);
        chk("illegal_noahb", n_ahb - k0, 32'd0);
        apb(16'h0080, 1, 32'hA5A5_5A5A, 4'b1111, 3'b000, 2, 1, 0, JUNK, 0, 0); idle(1);
        chk("wait_lat", last_resp - last_s, 32'd6);
        k0 = n_resp;
        apb(16'h0090, 1, 32'h0BAD_CAFE, 4'b1111, 3'b000, 0, 0, 0, JUNK, 0, 1); idle(2);
        chk("drop_resp", n_resp - k0, 32'd1);
        chk("drop_haddr", last_haddr, 32'hFFFF_1090);
        k0 = n_resp;
        apb(16'h00A0, 0, 32'h0, 4'b0000, 3'b000, 0, 3, 0, 32'h1357_9BDF, 2, 0);
        chk("mrst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("mrst_pready", 32'(bus.PREADY), 32'd0);
        chk("mrst_haddr", bus.HADDR, 32'd0);
        idle(3);
        chk("mrst_no_resp", n_resp - k0, 32'd0);
        apb(16'h00A4, 0, 32'h0, 4'b0000, 3'b000, 0, 0, 0, 32'hCAFE_F00D, 0, 0); idle(1);
        chk("post_rst_prdata", last_prdata, 32'hCAFE_F00D);
        chk("post_rst_lat", last_resp - last_s, 32'd3);
        k0 = n_ahb;
        k1 = n_resp;
        apb(16'h0040, 1, 32'h0102_0304, 4'b1111, 3'b000, 0, 0, 0, JUNK, 0, 0);
        apb(16'h0044, 0, 32'h0, 4'b0000, 3'b000, 0, 0, 0, 32'h0A0B_0C0D, 0, 0);
        apb(16'hFFFF, 1, 32'hEE00_0000, 4'b1000, 3'b000, 0, 0, 0, JUNK, 0, 0);
        idle(1);
        chk("b2b_wrap_haddr", last_haddr, 32'h0000_0FFF);
        chk("b2b_ahb_count", n_ahb - k0, 32'd3);
        chk("b2b_resp_count", n_resp - k1, 32'd3);
        apb(16'hFFFC, 0, 32'h0, 4'b0000, 3'b000, 0, 0, 0, 32'h2468_ACE0, 0, 0); idle(1);
        chk("wrap_rd_haddr", last_haddr, 32'h0000_0FFC);
        chk("wrap_rd_prdata", last_prdata, 32'h2468_ACE0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
